i2cmb_cmd_sequencer: RTL

I2CMB_CMD_SEQUENCER -- requirements
Module: i2cmb_cmd_sequencer

---
 rtl/i2cmb_cmd_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/i2cmb_cmd_sequencer.sv
// Runs one I2C byte transaction (write or read) through an I2CMB core's Wishbone registers.
// Optional macro I2CMB_SEQ_IRQ_EN: WAIT reads CMDR only after irq_i instead of polling.
module i2cmb_cmd_sequencer #(
    parameter int         WAIT_TIMEOUT = 4095,
    parameter logic [7:0] ENABLE_CSR   = 8'hC0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [3:0] req_bus_i,
    input  logic [6:0] req_addr_i,
    input  logic       req_rw_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [1:0] rsp_status_o,
    output logic [7:0] rsp_rdata_o,
    output logic [1:0] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    output logic       we_o,
    output logic       cyc_o,
    output logic       stb_o,
    input  logic       ack_i,
    input  logic       irq_i
);
    localparam int            CW     = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO    = CW'(WAIT_TIMEOUT);
    localparam logic [1:0]    A_CSR  = 2'd0;
    localparam logic [1:0]    A_DPR  = 2'd1;
    localparam logic [1:0]    A_CMDR = 2'd2;

`ifdef I2CMB_SEQ_IRQ_EN
    localparam logic [7:0] EN_VAL = ENABLE_CSR;
    logic poll_ok;
    assign poll_ok = irq_i;
`else
    localparam logic [7:0] EN_VAL = ENABLE_CSR & 8'hBF;
    logic poll_ok;
    // irq_i has no effect when polling; the OR keeps the port referenced.
    assign poll_ok = 1'b1 | irq_i;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_ENABLE, S_SETBUS, S_START, S_ADDR, S_DATA,
        S_RDNAK, S_RDDPR, S_STOP, S_WAIT, S_RESP
    } state_t;

    state_t        state_q, state_d, ret_q, ret_d, acc_next;
    logic          ph_q, ph_d, cyc_q, cyc_d, we_q, we_d, rw_q, rw_d, en_q, en_d;
    logic [1:0]    adr_q, adr_d, st_q, st_d, status_q, status_d;
    logic [7:0]    dat_q, dat_d, wdata_q, wdata_d, rbyte_q, rbyte_d, rdata_q, rdata_d;
    logic [3:0]    bus_q, bus_d;
    logic [6:0]    addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_two;
    logic [7:0]    acc_dpr, acc_cmd;

    // Register-write steps: optional DPR write (phase 0) then the CMDR command.
    always_comb begin
        acc_two  = 1'b0;
        acc_dpr  = 8'h00;
        acc_cmd  = 8'h00;
        acc_next = S_RESP;
        case (state_q)
            S_SETBUS: begin acc_two = 1'b1; acc_dpr = {4'h0, bus_q}; acc_cmd = 8'h06; acc_next = S_START; end
            S_START:  begin acc_cmd = 8'h04; acc_next = S_ADDR; end
            S_ADDR:   begin
                acc_two  = 1'b1;
                acc_dpr  = {addr_q, rw_q};
                acc_cmd  = 8'h01;
                acc_next = rw_q ? S_RDNAK : S_DATA;
            end
            S_DATA:   begin acc_two = 1'b1; acc_dpr = wdata_q; acc_cmd = 8'h01; acc_next = S_STOP; end
            S_RDNAK:  begin acc_cmd = 8'h03; acc_next = S_RDDPR; end
            S_STOP:   begin acc_cmd = 8'h05; acc_next = S_RESP; end
            default:  ;
        endcase
    end

    always_comb begin
        state_d  = state_q;  ret_d   = ret_q;   ph_d    = ph_q;
        cyc_d    = cyc_q;    we_d    = we_q;    adr_d   = adr_q;   dat_d = dat_q;
        bus_d    = bus_q;    addr_d  = addr_q;  rw_d    = rw_q;    wdata_d = wdata_q;
        en_d     = en_q;     cnt_d   = cnt_q;   st_d    = st_q;    rbyte_d = rbyte_q;
        status_d = status_q; rdata_d = rdata_q;
        case (state_q)
            S_IDLE: if (req_valid_i) begin
                bus_d   = req_bus_i;
                addr_d  = req_addr_i;
                rw_d    = req_rw_i;
                wdata_d = req_wdata_i;
                st_d    = 2'b00;
                rbyte_d = 8'h00;
                ph_d    = 1'b0;
                state_d = en_q ? S_SETBUS : S_ENABLE;
            end
            S_ENABLE: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1; we_d = 1'b1; adr_d = A_CSR; dat_d = EN_VAL;
                end else if (ack_i) begin
                    cyc_d = 1'b0; we_d = 1'b0; en_d = 1'b1; state_d = S_SETBUS;
                end
            end
            S_RDDPR: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1; we_d = 1'b0; adr_d = A_DPR;
                end else if (ack_i) begin
                    cyc_d = 1'b0; rbyte_d = dat_i; state_d = S_STOP;
                end
            end
            S_WAIT: begin
                if (cnt_q != TMO) cnt_d = cnt_q + CW'(1);
                if (cyc_q) begin
                    if (ack_i) begin
                        cyc_d = 1'b0;
                        if (dat_i[6]) begin
                            // A NAK while waiting on STOP itself just finishes.
                            if (ret_q == S_RESP) state_d = S_RESP;
                            else begin st_d = 2'b01; state_d = S_STOP; end
                        end else if (dat_i[5]) begin
                            st_d = 2'b10; state_d = S_RESP;
                        end else if (dat_i[4]) begin
                            st_d = 2'b11; state_d = S_RESP;
                        end else if (dat_i[7]) begin
                            state_d = ret_q;
                        end
                    end
                end else if (cnt_q == TMO) begin
                    st_d = 2'b11; en_d = 1'b0; state_d = S_RESP;
                end else if (poll_ok) begin
                    cyc_d = 1'b1; we_d = 1'b0; adr_d = A_CMDR;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = (acc_two && !ph_q) ? A_DPR : A_CMDR;
                    dat_d = (acc_two && !ph_q) ? acc_dpr : acc_cmd;
                end else if (ack_i) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    if (acc_two && !ph_q) ph_d = 1'b1;
                    else begin
                        ph_d = 1'b0; ret_d = acc_next; cnt_d = '0; state_d = S_WAIT;
                    end
                end
            end
        endcase
        // Response fields change only as RESP is entered, so they hold between responses.
        if (state_d == S_RESP && state_q != S_RESP) begin
            status_d = st_d;
            rdata_d  = rw_q ? rbyte_d : 8'h00;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE; ret_q   <= S_IDLE; ph_q    <= 1'b0;
            cyc_q    <= 1'b0;   we_q    <= 1'b0;   adr_q   <= 2'd0;  dat_q   <= 8'h00;
            bus_q    <= 4'h0;   addr_q  <= 7'h00;  rw_q    <= 1'b0;  wdata_q <= 8'h00;
            en_q     <= 1'b0;   cnt_q   <= '0;     st_q    <= 2'b00; rbyte_q <= 8'h00;
            status_q <= 2'b00;  rdata_q <= 8'h00;
        end else begin
            state_q  <= state_d;  ret_q   <= ret_d;   ph_q    <= ph_d;
            cyc_q    <= cyc_d;    we_q    <= we_d;    adr_q   <= adr_d;  dat_q   <= dat_d;
            bus_q    <= bus_d;    addr_q  <= addr_d;  rw_q    <= rw_d;   wdata_q <= wdata_d;
            en_q     <= en_d;     cnt_q   <= cnt_d;   st_q    <= st_d;   rbyte_q <= rbyte_d;
            status_q <= status_d; rdata_q <= rdata_d;
        end
    end

    assign req_ready_o  = (state_q == S_IDLE) && !rst_i;
    assign rsp_valid_o  = (state_q == S_RESP);
    assign rsp_status_o = status_q;
    assign rsp_rdata_o  = rdata_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;
    assign we_o         = we_q;
    assign adr_o        = adr_q;
    assign dat_o        = dat_q;
endmodule
